// File: rtl/oam_dma_controller_if.sv
// Bus bundle between the OAM DMA sequencer, the CPU register decode, the source bus and OAM.
// The controller is the master: it issues source reads and OAM writes.
interface oam_dma_controller_if;
  logic        start;
  logic [7:0]  start_page;
  logic [7:0]  page_rd;
  logic [15:0] dma_src_addr;
  logic [7:0]  dma_d_in;
  logic        dma_active;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_d_wr;
  logic        oam_write;
  logic        done;

  modport master (
    input  start, start_page, dma_d_in,
    output page_rd, dma_src_addr, dma_active, oam_addr, oam_d_wr, oam_write, done
  );

  modport slave (
    output start, start_page, dma_d_in,
    input  page_rd, dma_src_addr, dma_active, oam_addr, oam_d_wr, oam_write, done
  );
endinterface

// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: after a start strobe and a fixed delay, copies BYTES bytes from page {page,00}
// into OAM, one byte per CYCLES_PER_BYTE-clock slot. START_DELAY must be at least 1.
module oam_dma_controller #(
  parameter int BYTES           = 160,
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY     = 4
) (
  input logic                   clk,
  input logic                   rst,
  oam_dma_controller_if.master  bus
);

  localparam int PW = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [DW-1:0] DELAY_LAST = DW'(START_DELAY - 1);
  localparam logic [7:0]    IDX_LAST   = 8'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, DELAY, XFER} state_t;

  state_t        state, state_next;
  logic [7:0]    idx, idx_next;
  logic [PW-1:0] phase, phase_next;
  logic [DW-1:0] delay_cnt, delay_cnt_next;
  logic [15:0]   src_addr, src_addr_next;
  logic [7:0]    page_q, page_next;
  logic [7:0]    map_q, map_next;
  logic          done_q, done_next;
  logic          write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 8'h00;
      phase     <= '0;
      delay_cnt <= '0;
      src_addr  <= 16'h0000;
      page_q    <= 8'h00;
      map_q     <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      phase     <= phase_next;
      delay_cnt <= delay_cnt_next;
      src_addr  <= src_addr_next;
      page_q    <= page_next;
      map_q     <= map_next;
      done_q    <= done_next;
    end
  end

  always_comb begin
    state_next     = state;
    idx_next       = idx;
    phase_next     = phase;
    delay_cnt_next = delay_cnt;
    src_addr_next  = src_addr;
    page_next      = page_q;
    map_next       = map_q;
    done_next      = 1'b0;
    write          = 1'b0;

    case (state)
      DELAY: begin
        if (delay_cnt == DELAY_LAST) begin
          state_next    = XFER;
          phase_next    = '0;
          src_addr_next = {map_q, idx};
        end else begin
          delay_cnt_next = delay_cnt + 1'b1;
        end
      end
      XFER: begin
        if (phase == PHASE_LAST) begin
          write = 1'b1;
          if (idx == IDX_LAST) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            idx_next      = idx + 8'h01;
            phase_next    = '0;
            src_addr_next = {map_q, idx + 8'h01};
          end
        end else begin
          phase_next = phase + 1'b1;
        end
      end
      default: ;
    endcase

    // A new register write restarts from scratch and cancels whatever was due this clock.
    if (bus.start) begin
      state_next     = DELAY;
      idx_next       = 8'h00;
      phase_next     = '0;
      delay_cnt_next = '0;
      page_next      = bus.start_page;
      map_next       = (bus.start_page >= 8'hE0) ? (bus.start_page - 8'h20) : bus.start_page;
      done_next      = 1'b0;
      write          = 1'b0;
    end
  end

  assign bus.page_rd      = page_q;
  assign bus.dma_src_addr = src_addr;
  assign bus.dma_active   = (state == XFER);
  assign bus.oam_addr     = idx;
  assign bus.oam_write    = write;
  assign bus.oam_d_wr     = write ? bus.dma_d_in : 8'h00;
  assign bus.done         = done_q;

endmodule
